// File: rtl/fifo_arb.sv
// fifo_arb: round-robin two-master arbiter that sequences single-cycle FIFO reads/writes.
// Define FIFO_ARB_ERRCNT_EN to add per-master saturating error counters with err_clr.
module fifo_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef FIFO_ARB_ERRCNT_EN
  input  logic                  err_clr,
  output logic [7:0]            m0_errcnt,
  output logic [7:0]            m1_errcnt,
`endif
  input  logic                  m0_req,
  input  logic                  m0_rw,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_rw,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_wr_err,
  input  logic                  fifo_rd_ack,
  input  logic                  fifo_rd_err,
  input  logic [3:0]            fifo_count,
  output logic [1:0]            grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;
  localparam logic [3:0] full_lvl = 4'(FIFO_DEPTH);
  state_t state;
  logic rr_last, own, rw_q, pre_q;
  logic pick1, rw_sel, pre, ok;
  logic [DATA_WIDTH-1:0] wdata_sel;
  always_comb begin
    pick1 = m1_req && (!m0_req || !rr_last);
    rw_sel = pick1 ? m1_rw : m0_rw;
    wdata_sel = pick1 ? m1_wdata : m0_wdata;
    pre = rw_sel ? (fifo_count >= full_lvl) : (fifo_count == 4'd0);
    ok = !pre_q && (rw_q ? (fifo_wr_ack && !fifo_wr_err) : (fifo_rd_ack && !fifo_rd_err));
  end
  // A pre-check failure skips the strobe and enters RESP with pre_q forcing the error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_last <= 1'b1;
      own <= 1'b0;
      rw_q <= 1'b0;
      pre_q <= 1'b0;
      grant <= 2'b00;
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_din <= '0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: if (m0_req || m1_req) begin
          own <= pick1;
          rw_q <= rw_sel;
          pre_q <= pre;
          fifo_din <= wdata_sel;
          grant <= pick1 ? 2'b10 : 2'b01;
          fifo_wr_en <= !pre && rw_sel;
          fifo_rd_en <= !pre && !rw_sel;
          state <= pre ? RESP : ISSUE;
        end
        ISSUE: state <= RESP;
        RESP: begin
          m0_done <= !own;
          m1_done <= own;
          m0_err <= !own && !ok;
          m1_err <= own && !ok;
          if (ok && !rw_q && !own) m0_rdata <= fifo_dout;
          if (ok && !rw_q && own) m1_rdata <= fifo_dout;
          state <= DONE;
        end
        DONE: begin
          rr_last <= own;
          grant <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FIFO_ARB_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_errcnt <= 8'd0;
      m1_errcnt <= 8'd0;
    end else if (err_clr) begin
      m0_errcnt <= 8'd0;
      m1_errcnt <= 8'd0;
    end else begin
      if (m0_done && m0_err && m0_errcnt != 8'hff) m0_errcnt <= m0_errcnt + 8'd1;
      if (m1_done && m1_err && m1_errcnt != 8'hff) m1_errcnt <= m1_errcnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_arb.sv
// tb_fifo_arb: directed and randomized transactions against a transaction-level model
// of round-robin arbitration, FIFO occupancy and per-master read data.
module tb_fifo_arb;
  logic clk = 1'b0, reset_n = 1'b0;
  logic m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, fifo_din, fifo_dout = '0;
  logic m0_done, m0_err, m1_done, m1_err, fifo_wr_en, fifo_rd_en;
  logic fifo_wr_ack = 1'b0, fifo_wr_err = 1'b0, fifo_rd_ack = 1'b0, fifo_rd_err = 1'b0;
  logic [3:0] fifo_count;
  logic [1:0] grant;
`ifdef FIFO_ARB_ERRCNT_EN
  logic err_clr = 1'b0;
  logic [7:0] m0_errcnt, m1_errcnt;
`endif
  int errors = 0, checks = 0;
  int cnt_ovr = -1, occ = 0, extra = 0, sel;
  bit noflags = 1'b0, last_m1 = 1'b1, rr0, rr1, seen;
  logic [31:0] q[$], mq[$];
  logic [31:0] exp_rd[2] = '{32'd0, 32'd0};

  fifo_arb #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef FIFO_ARB_ERRCNT_EN
    .err_clr(err_clr), .m0_errcnt(m0_errcnt), .m1_errcnt(m1_errcnt),
`endif
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_wdata(m0_wdata), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_wdata(m1_wdata), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
    .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err), .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
    .fifo_count(fifo_count), .grant(grant)
  );

  always #5 clk = ~clk;
  assign fifo_count = cnt_ovr >= 0 ? 4'(cnt_ovr) : 4'(occ);

  // Shared 8-entry FIFO: flags answer the cycle after a strobe; noflags models a silent FIFO.
  always @(posedge clk) begin
    fifo_wr_ack <= 1'b0;
    fifo_wr_err <= 1'b0;
    fifo_rd_ack <= 1'b0;
    fifo_rd_err <= 1'b0;
    if (fifo_wr_en && !noflags) begin
      if (q.size() < 8) begin q.push_back(fifo_din); fifo_wr_ack <= 1'b1; end
      else fifo_wr_err <= 1'b1;
    end
    if (fifo_rd_en && !noflags) begin
      if (q.size() > 0) begin fifo_dout <= q.pop_front(); fifo_rd_ack <= 1'b1; end
      else fifo_rd_err <= 1'b1;
    end
    occ <= q.size();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                     input logic [31:0] d0, input logic [31:0] d1, input bit hold, input bit drop);
    bit win1, rw, pre, eerr, s_ok, g_ok;
    int cnt, lat, got_lat;
    logic [31:0] d;
    logic [1:0] eg, dn;
    m0_req = r0; m1_req = r1; m0_rw = w0; m1_rw = w1; m0_wdata = d0; m1_wdata = d1;
    win1 = r1 && (!r0 || !last_m1);
    rw = win1 ? w1 : w0;
    d = win1 ? d1 : d0;
    cnt = cnt_ovr >= 0 ? cnt_ovr : mq.size();
    pre = rw ? cnt >= 8 : cnt == 0;
    eerr = 1'b1;
    if (!pre && !noflags) begin
      if (rw && mq.size() < 8) begin mq.push_back(d); eerr = 1'b0; end
      else if (!rw && mq.size() > 0) begin exp_rd[win1] = mq.pop_front(); eerr = 1'b0; end
    end
    lat = extra + (pre ? 2 : 3);
    eg = win1 ? 2'b10 : 2'b01;
    got_lat = 0; dn = 2'b00; s_ok = 1'b1; g_ok = 1'b1;
    for (int c = 1; c <= extra + 6 && got_lat == 0; c++) begin
      @(negedge clk);
      if (drop && c == extra + 1) begin m0_req = 1'b0; m1_req = 1'b0; end
      s_ok &= (c == extra + 1 && !pre) ? (fifo_wr_en === rw && fifo_rd_en === !rw && fifo_din === d)
                                       : (fifo_wr_en === 1'b0 && fifo_rd_en === 1'b0);
      g_ok &= (grant === (c > extra ? eg : 2'b00));
      if (m0_done || m1_done) begin got_lat = c; dn = {m1_done, m0_done}; end
    end
    chk("latency", 32'(got_lat), 32'(lat));
    chk("done_owner", 32'(dn), 32'(eg));
    chk("err", 32'(win1 ? m1_err : m0_err), 32'(eerr));
    chk("rdata", win1 ? m1_rdata : m0_rdata, exp_rd[win1]);
    chk("strobe", 32'(s_ok), 32'd1);
    chk("grant", 32'(g_ok), 32'd1);
    last_m1 = win1;
    if (hold) extra = 1;
    else begin
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      extra = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_strobes", 32'({fifo_wr_en, fifo_rd_en}), 32'd0);
    chk("rst_done", 32'({m0_done, m1_done, m0_err, m1_err}), 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    txn(1, 0, 1, 0, 32'hA5A5A5A5, 32'd0, 0, 0);
    cnt_ovr = 8;
    txn(0, 1, 0, 1, 32'd0, 32'hDEADBEEF, 0, 0);
    cnt_ovr = -1;
    for (int i = 0; i < 4; i++) txn(1, 1, 1, 1, $urandom, $urandom, i < 3, 0);
    repeat (6) txn(1, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    txn(0, 1, 0, 1, 32'd0, 32'h12345678, 0, 0);
    txn(0, 1, 0, 1, 32'd0, 32'h00000001, 0, 0);
    txn(0, 1, 0, 1, 32'd0, 32'h00000002, 0, 0);
    txn(0, 1, 0, 0, 32'd0, 32'd0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", m1_rdata, 32'h12345678);
    txn(1, 0, 1, 0, 32'h0BADF00D, 32'd0, 0, 0);
    chk("rdata_hold2", m1_rdata, 32'h12345678);
    noflags = 1'b1;
    txn(1, 0, 1, 0, 32'hCAFEF00D, 32'd0, 0, 0);
    noflags = 1'b0;
    m0_req = 1'b1; m0_rw = 1'b1; m0_wdata = 32'h0000BEEF;
    @(negedge clk);
    chk("issue_wr_en", 32'(fifo_wr_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_drop_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_drop_grant", 32'(grant), 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= m0_done | m1_done; end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    last_m1 = 1'b1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    for (int i = 0; i < 60; i++) begin
      rr0 = 1'($urandom);
      rr1 = 1'($urandom);
      if (!rr0 && !rr1) rr0 = 1'b1;
      sel = $urandom_range(0, 7);
      cnt_ovr = sel == 5 ? 0 : sel == 6 ? 8 : sel == 7 ? 12 : -1;
      txn(rr0, rr1, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    cnt_ovr = -1;
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(negedge clk);
    extra = 0;
`ifdef FIFO_ARB_ERRCNT_EN
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("errcnt_clr", 32'(m0_errcnt), 32'd0);
    cnt_ovr = 0;
    repeat (300) txn(1, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    chk("errcnt_sat", 32'(m0_errcnt), 32'd255);
    chk("errcnt_m1", 32'(m1_errcnt), 32'd0);
    err_clr = 1'b1;
    txn(1, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    err_clr = 1'b0;
    chk("errcnt_clr_wins", 32'(m0_errcnt), 32'd0);
    cnt_ovr = -1;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
